// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared VGA timing sets and frame-geometry helper functions.
// Revision    : 1.0 - initial parametrised timing package
// ============================================================================
package vga_pkg;

  // One complete timing set: porch/sync widths and sync polarities.
  typedef struct packed {
    logic [11:0] h_active;
    logic [11:0] h_front;
    logic [11:0] h_sync;
    logic [11:0] h_back;
    logic [11:0] v_active;
    logic [11:0] v_front;
    logic [11:0] v_sync;
    logic [11:0] v_back;
    logic        hs_pol;
    logic        vs_pol;
  } vga_timing_t;

  // 640x480 @ 60 Hz, 25 MHz pixel clock, both syncs active-low.
  localparam vga_timing_t VGA_640x480_60 = '{
    h_active: 12'd640, h_front: 12'd16, h_sync: 12'd96, h_back: 12'd48,
    v_active: 12'd480, v_front: 12'd10, v_sync: 12'd2,  v_back: 12'd33,
    hs_pol: 1'b0, vs_pol: 1'b0};

  // 800x600 @ 60 Hz, 40 MHz pixel clock, both syncs active-high.
  localparam vga_timing_t VGA_800x600_60 = '{
    h_active: 12'd800, h_front: 12'd40, h_sync: 12'd128, h_back: 12'd88,
    v_active: 12'd600, v_front: 12'd1,  v_sync: 12'd4,   v_back: 12'd23,
    hs_pol: 1'b1, vs_pol: 1'b1};

  // Total length of one axis: visible + front porch + sync + back porch.
  function automatic int line_total(input int active, input int front,
                                    input int sync, input int back);
    return active + front + sync + back;
  endfunction

  function automatic int h_total(input vga_timing_t t);
    return line_total(int'(t.h_active), int'(t.h_front), int'(t.h_sync), int'(t.h_back));
  endfunction

  function automatic int v_total(input vga_timing_t t);
    return line_total(int'(t.v_active), int'(t.v_front), int'(t.v_sync), int'(t.v_back));
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : pixel_delay_line
// Description : Tick-enabled shift register of DEPTH stages; DEPTH=0 passes
//               the input straight through.
// Revision    : 1.0 - initial version
// ============================================================================
module pixel_delay_line #(
  parameter int              WIDTH     = 3,
  parameter int              DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_pass
      // Control inputs have no function without storage.
      logic unused_ctrl;
      assign unused_ctrl = ^{clk_i, rst_ni, tick_i, clr_i};
      assign q_o = d_i;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];

      // Advance one stage per tick; clear returns every stage to the idle value.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
        end else if (clr_i) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
        end else if (tick_i) begin
          stage_q[0] <= d_i;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign q_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised VGA timing: pixel-tick divider, h/v counters,
//               sync/blank generation delayed to match renderer latency, and
//               gated, registered colour outputs.
// Revision    : 1.0 - initial parametrised version
// ============================================================================
module vga_timing_gen import vga_pkg::*; #(
  parameter int   CLK_DIV  = 4,
  parameter int   H_ACTIVE = int'(VGA_640x480_60.h_active),
  parameter int   H_FRONT  = int'(VGA_640x480_60.h_front),
  parameter int   H_SYNC   = int'(VGA_640x480_60.h_sync),
  parameter int   H_BACK   = int'(VGA_640x480_60.h_back),
  parameter int   V_ACTIVE = int'(VGA_640x480_60.v_active),
  parameter int   V_FRONT  = int'(VGA_640x480_60.v_front),
  parameter int   V_SYNC   = int'(VGA_640x480_60.v_sync),
  parameter int   V_BACK   = int'(VGA_640x480_60.v_back),
  parameter logic HS_POL   = VGA_640x480_60.hs_pol,
  parameter logic VS_POL   = VGA_640x480_60.vs_pol,
  parameter int   CNT_W    = 10,
  parameter int   PIPE     = 2
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             enable_i,
  input  logic [11:0]      rgbIn_i,
  output logic             pTick_o,
  output logic [CNT_W-1:0] pixelX_o,
  output logic [CNT_W-1:0] pixelY_o,
  output logic             lineTick_o,
  output logic             frameTick_o,
  output logic             hSync_o,
  output logic             vSync_o,
  output logic             videoON_o,
  output logic [3:0]       vgaRed_o,
  output logic [3:0]       vgaGreen_o,
  output logic [3:0]       vgaBlue_o
);

  localparam int H_TOTAL = line_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = line_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] X_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] Y_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] X_HS_BEG = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] X_HS_END = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] Y_VS_BEG = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] Y_VS_END = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  // Refuse to build a configuration whose counters or pipeline cannot work.
  generate
    if ((H_TOTAL - 1) >= (1 << CNT_W) || (V_TOTAL - 1) >= (1 << CNT_W)) begin : g_cnt_w_too_small
      $error("vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
    end
    if (CLK_DIV < 1) begin : g_clk_div_illegal
      $error("vga_timing_gen: CLK_DIV must be >= 1");
    end
    if (PIPE < 0 || PIPE > 8) begin : g_pipe_illegal
      $error("vga_timing_gen: PIPE must be in 0..8");
    end
  endgenerate

  logic [DIV_W-1:0] div_q;
  logic             pTick_q;
  logic [CNT_W-1:0] pixelX_q, pixelX_d;
  logic [CNT_W-1:0] pixelY_q, pixelY_d;
  logic             line_wrap;
  logic [2:0]       raw_flags;   // {active, hs, vs}, asserted-high
  logic [2:0]       dly_flags;
  logic             hSync_q, vSync_q, videoON_q;
  logic [11:0]      rgb_q;

  // Clock divider: pTick is high for the one clock after the divider hits its last count.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      div_q   <= '0;
      pTick_q <= 1'b0;
    end else if (!enable_i) begin
      div_q   <= '0;
      pTick_q <= 1'b0;
    end else begin
      pTick_q <= (div_q == DIV_LAST);
      div_q   <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end
  end

  assign line_wrap = (pixelX_q == X_LAST);

  // Next raster position: advance on each pixel tick, wrapping line then frame.
  always_comb begin
    pixelX_d = pixelX_q;
    pixelY_d = pixelY_q;
    if (pTick_q) begin
      if (line_wrap) begin
        pixelX_d = '0;
        pixelY_d = (pixelY_q == Y_LAST) ? '0 : pixelY_q + CNT_W'(1);
      end else begin
        pixelX_d = pixelX_q + CNT_W'(1);
      end
    end
  end

  // Raster counters, held at the origin while disabled.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pixelX_q <= '0;
      pixelY_q <= '0;
    end else if (!enable_i) begin
      pixelX_q <= '0;
      pixelY_q <= '0;
    end else begin
      pixelX_q <= pixelX_d;
      pixelY_q <= pixelY_d;
    end
  end

  assign raw_flags[2] = (pixelX_q < X_ACT) && (pixelY_q < Y_ACT);
  assign raw_flags[1] = (pixelX_q >= X_HS_BEG) && (pixelX_q <= X_HS_END);
  assign raw_flags[0] = (pixelY_q >= Y_VS_BEG) && (pixelY_q <= Y_VS_END);

  // Delay the raw flags by the renderer latency so they meet its colour.
  pixel_delay_line #(
    .WIDTH     (3),
    .DEPTH     (PIPE),
    .RESET_VAL (3'b000)
  ) u_flag_dly (
    .clk_i  (clock_i),
    .rst_ni (reset_ni),
    .tick_i (pTick_q),
    .clr_i  (~enable_i),
    .d_i    (raw_flags),
    .q_o    (dly_flags)
  );

  // Pin registers: polarity applied here, colour forced to black outside the active area.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      hSync_q   <= ~HS_POL;
      vSync_q   <= ~VS_POL;
      videoON_q <= 1'b0;
      rgb_q     <= 12'h000;
    end else if (!enable_i) begin
      hSync_q   <= ~HS_POL;
      vSync_q   <= ~VS_POL;
      videoON_q <= 1'b0;
      rgb_q     <= 12'h000;
    end else if (pTick_q) begin
      hSync_q   <= dly_flags[1] ? HS_POL : ~HS_POL;
      vSync_q   <= dly_flags[0] ? VS_POL : ~VS_POL;
      videoON_q <= dly_flags[2];
      rgb_q     <= dly_flags[2] ? rgbIn_i : 12'h000;
    end
  end

  assign pTick_o     = pTick_q;
  assign pixelX_o    = pixelX_q;
  assign pixelY_o    = pixelY_q;
  assign lineTick_o  = pTick_q && line_wrap;
  assign frameTick_o = pTick_q && line_wrap && (pixelY_q == Y_LAST);
  assign hSync_o     = hSync_q;
  assign vSync_o     = vSync_q;
  assign videoON_o   = videoON_q;
  assign vgaRed_o    = rgb_q[11:8];
  assign vgaGreen_o  = rgb_q[7:4];
  assign vgaBlue_o   = rgb_q[3:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Directed bench: a default 640x480 build (CLK_DIV=4, PIPE=2)
//               and a tiny 16x9 build (CLK_DIV=1, PIPE=0).
// Revision    : 1.0 - initial version
// ============================================================================
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------- default build ----------------
  logic        rst_a, en_a, mode_a;
  logic [11:0] rgb_a;
  logic        pTick_a, lineTick_a, frameTick_a, hSync_a, vSync_a, videoON_a;
  logic [9:0]  pixelX_a, pixelY_a;
  logic [3:0]  r_a, g_a, b_a;
  logic [11:0] col_a;
  assign col_a = {r_a, g_a, b_a};

  vga_timing_gen u_dut_a (
    .clock_i(clk), .reset_ni(rst_a), .enable_i(en_a), .rgbIn_i(rgb_a),
    .pTick_o(pTick_a), .pixelX_o(pixelX_a), .pixelY_o(pixelY_a),
    .lineTick_o(lineTick_a), .frameTick_o(frameTick_a),
    .hSync_o(hSync_a), .vSync_o(vSync_a), .videoON_o(videoON_a),
    .vgaRed_o(r_a), .vgaGreen_o(g_a), .vgaBlue_o(b_a));

  // Renderer model: constant white, or a colour equal to the pixel index two ticks back.
  always @(negedge clk) rgb_a = mode_a ? 12'hFFF : (12'(pixelX_a) - 12'd2);

  // ---------------- tiny build ----------------
  logic        rst_b, en_b;
  logic [11:0] rgb_b;
  logic        pTick_b, lineTick_b, frameTick_b, hSync_b, vSync_b, videoON_b;
  logic [3:0]  pixelX_b, pixelY_b;
  logic [3:0]  r_b, g_b, b_b;
  logic [11:0] col_b;
  assign col_b = {r_b, g_b, b_b};

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(4), .PIPE(0)
  ) u_dut_b (
    .clock_i(clk), .reset_ni(rst_b), .enable_i(en_b), .rgbIn_i(rgb_b),
    .pTick_o(pTick_b), .pixelX_o(pixelX_b), .pixelY_o(pixelY_b),
    .lineTick_o(lineTick_b), .frameTick_o(frameTick_b),
    .hSync_o(hSync_b), .vSync_o(vSync_b), .videoON_o(videoON_b),
    .vgaRed_o(r_b), .vgaGreen_o(g_b), .vgaBlue_o(b_b));

  // ------------------------------------------------------------------------
  task automatic test_reset();
    rst_a = 1'b0; en_a = 1'b1; mode_a = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (pTick_a !== 1'b0) begin tests_failed++; $display("FAIL reset_ptick: got %b want 0", pTick_a); end
    tests_run++; if (pixelX_a !== 10'd0) begin tests_failed++; $display("FAIL reset_x: got %0d want 0", pixelX_a); end
    tests_run++; if (pixelY_a !== 10'd0) begin tests_failed++; $display("FAIL reset_y: got %0d want 0", pixelY_a); end
    tests_run++; if (hSync_a !== 1'b1) begin tests_failed++; $display("FAIL reset_hsync: got %b want 1", hSync_a); end
    tests_run++; if (vSync_a !== 1'b1) begin tests_failed++; $display("FAIL reset_vsync: got %b want 1", vSync_a); end
    tests_run++; if (videoON_a !== 1'b0) begin tests_failed++; $display("FAIL reset_videoon: got %b want 0", videoON_a); end
    tests_run++; if (col_a !== 12'h000) begin tests_failed++; $display("FAIL reset_colour: got %h want 000", col_a); end
    tests_run++; if (lineTick_a !== 1'b0 || frameTick_a !== 1'b0) begin tests_failed++; $display("FAIL reset_ticks: got %b%b want 00", lineTick_a, frameTick_a); end
  endtask

  task automatic test_ptick_cadence();
    int n;
    rst_a = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!pTick_a && n < 20);
    tests_run++; if (n !== 4) begin tests_failed++; $display("FAIL first_ptick_clocks: got %0d want 4", n); end
    tests_run++; if (pixelX_a !== 10'd0) begin tests_failed++; $display("FAIL first_ptick_x: got %0d want 0", pixelX_a); end
    n = 0;
    do begin @(negedge clk); n++; end while (!pTick_a && n < 20);
    tests_run++; if (n !== 4) begin tests_failed++; $display("FAIL ptick_period: got %0d want 4", n); end
    tests_run++; if (pixelX_a !== 10'd1) begin tests_failed++; $display("FAIL second_ptick_x: got %0d want 1", pixelX_a); end
  endtask

  task automatic test_line_wrap();
    int n;
    bit found;
    found = 1'b0;
    for (n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (pTick_a && pixelX_a == 10'd799) begin found = 1'b1; break; end
    end
    tests_run++; if (found !== 1'b1) begin tests_failed++; $display("FAIL wrap_reach: got %b want 1", found); end
    tests_run++; if (lineTick_a !== 1'b1) begin tests_failed++; $display("FAIL wrap_linetick: got %b want 1", lineTick_a); end
    tests_run++; if (frameTick_a !== 1'b0) begin tests_failed++; $display("FAIL wrap_frametick: got %b want 0", frameTick_a); end
    n = 0;
    do begin @(negedge clk); n++; end while (!pTick_a && n < 8);
    tests_run++; if (pixelX_a !== 10'd0 || pixelY_a !== 10'd1) begin tests_failed++; $display("FAIL wrap_next: got (%0d,%0d) want (0,1)", pixelX_a, pixelY_a); end
    tests_run++; if (lineTick_a !== 1'b0) begin tests_failed++; $display("FAIL nonwrap_linetick: got %b want 0", lineTick_a); end
  endtask

  // Starts on the tick where line 1 begins; walks the whole line.
  task automatic test_line_timing();
    int ticks, hs_ticks, hs_clks, vo_ticks, first_hs, first_vo, col_err, vs_low;
    bit done;
    logic [11:0] first_col;
    ticks = 0; hs_ticks = 0; hs_clks = 0; vo_ticks = 0; first_hs = -1; first_vo = -1;
    col_err = 0; vs_low = 0; done = 1'b0; first_col = 12'hBAD;
    for (int n = 0; n < 3300; n++) begin
      if (pTick_a && ticks > 0 && pixelX_a == 10'd0) begin done = 1'b1; break; end
      if (hSync_a == 1'b0) hs_clks++;
      if (vSync_a == 1'b0) vs_low++;
      if (pTick_a) begin
        if (hSync_a == 1'b0) begin hs_ticks++; if (first_hs < 0) first_hs = ticks; end
        if (videoON_a) begin
          vo_ticks++;
          if (first_vo < 0) begin first_vo = ticks; first_col = col_a; end
          if (col_a !== (12'(pixelX_a) - 12'd3)) col_err++;
        end else if (col_a !== 12'h000) col_err++;
        ticks++;
      end
      @(negedge clk);
    end
    tests_run++; if (done !== 1'b1 || ticks !== 800) begin tests_failed++; $display("FAIL line_ticks: got %0d (done=%b) want 800", ticks, done); end
    tests_run++; if (first_hs !== 659) begin tests_failed++; $display("FAIL hsync_start: got %0d want 659", first_hs); end
    tests_run++; if (hs_ticks !== 96) begin tests_failed++; $display("FAIL hsync_ticks: got %0d want 96", hs_ticks); end
    tests_run++; if (hs_clks !== 384) begin tests_failed++; $display("FAIL hsync_clocks: got %0d want 384", hs_clks); end
    tests_run++; if (vo_ticks !== 640) begin tests_failed++; $display("FAIL videoon_ticks: got %0d want 640", vo_ticks); end
    tests_run++; if (first_vo !== 3) begin tests_failed++; $display("FAIL videoon_start: got %0d want 3", first_vo); end
    tests_run++; if (first_col !== 12'h000) begin tests_failed++; $display("FAIL first_pixel_colour: got %h want 000", first_col); end
    tests_run++; if (col_err !== 0) begin tests_failed++; $display("FAIL colour_track: got %0d bad ticks want 0", col_err); end
    tests_run++; if (vs_low !== 0) begin tests_failed++; $display("FAIL vsync_line1: got %0d low clocks want 0", vs_low); end
  endtask

  task automatic test_colour_const();
    int ticks, white, bad;
    bit found;
    mode_a = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 3300; n++) begin
      @(negedge clk);
      if (pTick_a && pixelX_a == 10'd0) begin found = 1'b1; break; end
    end
    tests_run++; if (found !== 1'b1) begin tests_failed++; $display("FAIL const_line_start: got %b want 1", found); end
    ticks = 0; white = 0; bad = 0;
    while (ticks < 800) begin
      if (pTick_a) begin
        if (videoON_a && col_a === 12'hFFF) white++;
        else if (videoON_a || col_a !== 12'h000) bad++;
        ticks++;
      end
      @(negedge clk);
    end
    tests_run++; if (white !== 640) begin tests_failed++; $display("FAIL const_white_ticks: got %0d want 640", white); end
    tests_run++; if (bad !== 0) begin tests_failed++; $display("FAIL const_blank_colour: got %0d bad ticks want 0", bad); end
  endtask

  task automatic test_enable_drop();
    int n;
    bit found;
    found = 1'b0;
    for (n = 0; n < 3300; n++) begin
      @(negedge clk);
      if (pTick_a && pixelX_a == 10'd300) begin found = 1'b1; break; end
    end
    tests_run++; if (found !== 1'b1 || videoON_a !== 1'b1) begin tests_failed++; $display("FAIL drop_reach: got found=%b videoON=%b want 1/1", found, videoON_a); end
    en_a = 1'b0;
    @(negedge clk);
    tests_run++; if (pTick_a !== 1'b0) begin tests_failed++; $display("FAIL drop_ptick: got %b want 0", pTick_a); end
    tests_run++; if (pixelX_a !== 10'd0 || pixelY_a !== 10'd0) begin tests_failed++; $display("FAIL drop_counters: got (%0d,%0d) want (0,0)", pixelX_a, pixelY_a); end
    tests_run++; if (hSync_a !== 1'b1 || vSync_a !== 1'b1) begin tests_failed++; $display("FAIL drop_syncs: got h=%b v=%b want 1/1", hSync_a, vSync_a); end
    tests_run++; if (videoON_a !== 1'b0 || col_a !== 12'h000) begin tests_failed++; $display("FAIL drop_blank: got videoON=%b colour=%h want 0/000", videoON_a, col_a); end
    repeat (6) @(negedge clk);
    tests_run++; if (pTick_a !== 1'b0 || pixelX_a !== 10'd0) begin tests_failed++; $display("FAIL drop_hold: got ptick=%b x=%0d want 0/0", pTick_a, pixelX_a); end
    en_a = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!pTick_a && n < 20);
    tests_run++; if (n !== 4) begin tests_failed++; $display("FAIL reenable_clocks: got %0d want 4", n); end
    tests_run++; if (pixelX_a !== 10'd0 || pixelY_a !== 10'd0) begin tests_failed++; $display("FAIL reenable_pos: got (%0d,%0d) want (0,0)", pixelX_a, pixelY_a); end
  endtask

  task automatic test_small_build();
    int lows;
    tests_run++; if (pTick_b !== 1'b0 || hSync_b !== 1'b1 || vSync_b !== 1'b1) begin tests_failed++; $display("FAIL small_reset: got ptick=%b h=%b v=%b want 0/1/1", pTick_b, hSync_b, vSync_b); end
    rst_b = 1'b1;
    @(negedge clk);
    tests_run++; if (pTick_b !== 1'b1 || pixelX_b !== 4'd0) begin tests_failed++; $display("FAIL small_first_tick: got ptick=%b x=%0d want 1/0", pTick_b, pixelX_b); end
    @(negedge clk);
    tests_run++; if (pixelX_b !== 4'd1) begin tests_failed++; $display("FAIL small_x_step: got %0d want 1", pixelX_b); end
    lows = 0;
    repeat (40) begin @(negedge clk); if (pTick_b !== 1'b1) lows++; end
    tests_run++; if (lows !== 0) begin tests_failed++; $display("FAIL small_ptick_const: got %0d low clocks want 0", lows); end
  endtask

  task automatic test_small_frame();
    int period, vs_low, first_vs, hs_low, first_hs, vo, col_err, lines;
    bit found;
    found = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (frameTick_b) begin found = 1'b1; break; end
    end
    tests_run++; if (found !== 1'b1) begin tests_failed++; $display("FAIL small_frame_reach: got %b want 1", found); end
    period = -1; vs_low = 0; first_vs = -1; hs_low = 0; first_hs = -1; vo = 0; col_err = 0; lines = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (vSync_b == 1'b0) begin vs_low++; if (first_vs < 0) first_vs = n; end
      if (hSync_b == 1'b0) begin hs_low++; if (first_hs < 0) first_hs = n; end
      if (videoON_b) begin vo++; if (col_b !== 12'hA5C) col_err++; end
      else if (col_b !== 12'h000) col_err++;
      if (lineTick_b) lines++;
      if (frameTick_b) begin period = n; break; end
    end
    tests_run++; if (period !== 144) begin tests_failed++; $display("FAIL small_frame_period: got %0d want 144", period); end
    tests_run++; if (first_vs !== 82) begin tests_failed++; $display("FAIL small_vsync_start: got %0d want 82", first_vs); end
    tests_run++; if (vs_low !== 32) begin tests_failed++; $display("FAIL small_vsync_clocks: got %0d want 32", vs_low); end
    tests_run++; if (first_hs !== 12) begin tests_failed++; $display("FAIL small_hsync_start: got %0d want 12", first_hs); end
    tests_run++; if (hs_low !== 27) begin tests_failed++; $display("FAIL small_hsync_clocks: got %0d want 27", hs_low); end
    tests_run++; if (vo !== 32) begin tests_failed++; $display("FAIL small_videoon: got %0d want 32", vo); end
    tests_run++; if (col_err !== 0) begin tests_failed++; $display("FAIL small_colour_gate: got %0d bad clocks want 0", col_err); end
    tests_run++; if (lines !== 9) begin tests_failed++; $display("FAIL small_lineticks: got %0d want 9", lines); end
  endtask

  task automatic test_reset_mid_vsync();
    bit found;
    found = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (vSync_b == 1'b0) begin found = 1'b1; break; end
    end
    tests_run++; if (found !== 1'b1) begin tests_failed++; $display("FAIL midvs_reach: got %b want 1", found); end
    #2 rst_b = 1'b0;
    #1;
    tests_run++; if (vSync_b !== 1'b1) begin tests_failed++; $display("FAIL midvs_async_vsync: got %b want 1", vSync_b); end
    tests_run++; if (pixelX_b !== 4'd0 || pixelY_b !== 4'd0 || pTick_b !== 1'b0) begin tests_failed++; $display("FAIL midvs_async_state: got x=%0d y=%0d ptick=%b want 0/0/0", pixelX_b, pixelY_b, pTick_b); end
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  // ------------------------------------------------------------------------
  initial begin
    rst_a = 1'b0; en_a = 1'b1; mode_a = 1'b0;
    rst_b = 1'b0; en_b = 1'b1; rgb_b = 12'hA5C;
    test_reset();
    test_ptick_cadence();
    test_line_wrap();
    test_line_timing();
    test_colour_const();
    test_enable_drop();
    test_small_build();
    test_small_frame();
    test_reset_mid_vsync();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Hard stop if something stalls far beyond the expected run length.
  initial begin
    #600000;
    $display("FAIL watchdog: got timeout at %0t want completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised successor to the fixed 640x480 VGA sync/top pairing. It generates the pixel-tick enable, h/v counters, sync pulses and blanking for any timing set. It also delays sync/blank by a configurable pipeline depth so colour from a multi-stage renderer (paddle/ball/bricks) lines up at the pins. It sits between the board clock and the game renderer and drives hSync/vSync/vgaRed/vgaGreen/vgaBlue directly.

Parameters:
CLK_DIV, 4, board clocks per pixel; legal >= 1 (100 MHz -> 25 MHz)
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, h front porch (pixels)
H_SYNC, 96, h sync width (pixels)
H_BACK, 48, h back porch (pixels)
V_ACTIVE, 480, visible lines
V_FRONT, 10, v front porch (lines)
V_SYNC, 2, v sync width (lines)
V_BACK, 33, v back porch (lines)
HS_POL, 0, hSync asserted level (0 = active-low)
VS_POL, 0, vSync asserted level
CNT_W, 10, pixelX/pixelY width; must hold H_TOTAL-1 and V_TOTAL-1
PIPE, 2, renderer latency in pixel ticks (0..8); sync/blank delayed by this amount

Ports:
clock  in  1  board clock
reset  in  1  asynchronous, active-low reset
enable  in  1  sync run; low freezes and blanks the output
rgbIn  in  12  renderer colour {R,G,B}, valid PIPE ticks after the matching pixelX/pixelY
pTick  out  1  one-clock pixel enable
pixelX  out  CNT_W  current h count (undelayed, for the renderer)
pixelY  out  CNT_W  current v count (undelayed)
lineTick  out  1  pulses with the pTick on which pixelX wraps to 0
frameTick  out  1  pulses with the pTick on which both counters wrap to 0
hSync  out  1  delayed h sync
vSync  out  1  delayed v sync
videoON  out  1  delayed active-area flag
vgaRed  out  4  gated colour
vgaGreen  out  4  gated colour
vgaBlue  out  4  gated colour

Behaviour:
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525).
- Reset (reset=0, async): divider=0, pixelX=pixelY=0, pTick/lineTick/frameTick=0, hSync=~HS_POL, vSync=~VS_POL, videoON=0, colour=0, delay line cleared to the blank/deasserted state.
- Divider counts 0..CLK_DIV-1 on every clock while enable=1. pTick is registered and high for exactly the one clock after the divider reaches CLK_DIV-1. With CLK_DIV=1, pTick is high every clock.
- On pTick: pixelX increments. At H_TOTAL-1 it wraps to 0 and pixelY increments. pixelY wraps at V_TOTAL-1. lineTick and frameTick are combinational from pTick and the wrap condition.
- Raw flags, from the undelayed counts:
  - active = pixelX<H_ACTIVE && pixelY<V_ACTIVE
  - hs asserted for pixelX in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1]
  - vs asserted similarly on pixelY
- Delay line: PIPE stages of {active,hs,vs}, shifting only on pTick. Output register is updated on pTick. Outputs therefore lag the counts by PIPE+1 ticks in total, including the output register. The renderer must meet PIPE+1-tick latency, its own register included.
- Colour: vga* = rgbIn fields when delayed active=1, else 0, registered on pTick. Never nonzero while videoON=0.
- Colour/sync outputs change only on pTick clocks and are glitch-free, since all are registered.
- enable=0 (sampled each clock): divider, counters and delay line are synchronously cleared and held. pTick=0. Syncs are deasserted, colour is 0, videoON=0.
- enable rising: first pTick occurs CLK_DIV clocks later, with pixelX=0, pixelY=0.
- Reset mid-frame: immediate return to the reset state, with no partial sync pulse held.
- Counter width: the implementation must elaborate-time check CNT_W against H_TOTAL/V_TOTAL and stop with an error if too small.

Decomposition:
- Shared package vga_pkg holds:
  - timing constant sets VGA_640x480_60 and VGA_800x600_60 (porch/sync values, polarity)
  - localparam H_TOTAL/V_TOTAL helper functions
- One sub-module: pixel_delay_line (params WIDTH, DEPTH). Shift register advancing on a tick enable, async active-low reset to a parameter RESET_VAL; DEPTH=0 is a pass-through.

Test Plan:
- Reset released, enable=1, defaults -> pTick first high on the 4th clock, then every 4 clocks. pixelX goes 0,1,2… and wraps 799->0 with lineTick high on that tick.
- Run one line -> hSync low for exactly 96 ticks (384 clocks), starting 659 ticks after pixelX=0 (656 plus PIPE+1=3). videoON high for 640 ticks per active line.
- Run a full frame -> frameTick period 1,680,000 clocks. vSync low for 2 lines (1600 ticks) starting at line 490 plus a 3-tick lag. videoON=0 for lines 480..524.
- rgbIn=12'hFFF constant -> vga* = F only while videoON=1 and 0 in blanking. Feed rgbIn = pixelX[11:0] delayed 3 ticks -> first visible pixel shows value 0.
- Drop enable mid-line at pixelX=300 -> next clock pTick=0, counters 0, hSync/vSync=1, colour 0. Re-enable -> first pTick after 4 clocks at (0,0).
- Assert reset mid-vsync pulse -> vSync returns to 1 asynchronously, before the next clock edge. CLK_DIV=1, PIPE=0 build -> pTick constant 1, syncs lag counts by 1 clock.
